// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the convolution result reader:
//     DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default operand / operand-address widths
//     rd_state_t                      : reader FSM states
//     z_word_t                        : one MEMZ word at default widths
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rd_state_t;

  typedef logic [2*DEF_DATA_WIDTH-1:0] z_word_t;

endpackage

// File: rtl/conv_result_reader_if.sv
// ---------------------------------------------------------------------------
// conv_result_reader_if
//   Bundles the MEMZ read port and the result stream.
//   master (reader) : drives memZ_addr, m_data, m_valid, m_last; sees dataZ, m_ready
//   slave  (memory + stream sink) : the mirror image
//   memZ_addr : MEMZ read address (ADDR_WIDTH+1 bits)
//   dataZ     : MEMZ read data, one cycle after the address is sampled
//   m_data / m_valid / m_ready / m_last : valid/ready result stream
// ---------------------------------------------------------------------------
interface conv_result_reader_if #(
  parameter int DATA_WIDTH = conv_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = conv_pkg::DEF_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH:0]     memZ_addr;
  logic [2*DATA_WIDTH-1:0] dataZ;
  logic [2*DATA_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;

  modport master (
    output memZ_addr, m_data, m_valid, m_last,
    input  dataZ, m_ready
  );

  modport slave (
    input  memZ_addr, m_data, m_valid, m_last,
    output dataZ, m_ready
  );

endinterface

// File: rtl/conv_rd_skid_buf.sv
// ---------------------------------------------------------------------------
// conv_rd_skid_buf
//   Two-entry FIFO holding {last,data} beats between the MEMZ read port and
//   the output stream. The head entry is a register and drives the stream
//   directly, so m_data/m_last are glitch-free and stay put while stalled.
//   Ports:
//     clk, rstn             : clock, asynchronous active-low reset
//     i_push, i_push_last,
//     i_push_data           : write one beat
//     i_pop                 : consume the head beat (ignored when empty)
//     o_valid, o_last,
//     o_data                : head beat (o_last qualified by o_valid)
//     o_count               : occupancy 0..2
// ---------------------------------------------------------------------------
module conv_rd_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic         i_push_last,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_last,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head_data;
  logic         r_head_last;
  logic [W-1:0] r_tail_data;
  logic         r_tail_last;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head_data <= i_push_data;
            r_head_last <= i_push_last;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            // Pass-through: the new beat replaces the departing head.
            r_head_data <= i_push_data;
            r_head_last <= i_push_last;
          end else if (i_push) begin
            r_tail_data <= i_push_data;
            r_tail_last <= i_push_last;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            if (i_push) begin
              r_tail_data <= i_push_data;
              r_tail_last <= i_push_last;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_last  = r_head_last && o_valid;
  assign o_data  = r_head_data;
  assign o_count = r_count;

endmodule

// File: rtl/conv_result_reader.sv
// ---------------------------------------------------------------------------
// conv_result_reader
//   Drains MEMZ after a convolution: on start reads Z[0..sizeX+sizeY-2]
//   through the 1-cycle-latency read port and streams the words out on a
//   valid/ready interface, flagging the last beat. One beat per cycle when
//   the sink is always ready; never drops or duplicates under backpressure.
//   Ports:
//     clk, rstn      : clock, asynchronous active-low reset
//     start          : one-cycle pulse, accepted only in IDLE
//     sizeX, sizeY   : operand lengths, latched on accepted start
//     busy_out       : high from accepted start through the done cycle
//     done_out       : one-cycle pulse after the final beat transfers
//     checksum_out   : (CONV_RD_CHECKSUM_EN only) running sum of streamed data
//     bus            : conv_result_reader_if.master (MEMZ read port + stream)
//   Build option: define CONV_RD_CHECKSUM_EN to add checksum_out.
// ---------------------------------------------------------------------------
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   sizeX,
  input  logic [ADDR_WIDTH-1:0]   sizeY,
  output logic                    busy_out,
  output logic                    done_out,
`ifdef CONV_RD_CHECKSUM_EN
  output logic [2*DATA_WIDTH-1:0] checksum_out,
`endif
  conv_result_reader_if.master    bus
);

  localparam logic [ADDR_WIDTH:0] L_ONE = 1;

  rd_state_t               r_state;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH:0]     r_issue_cnt;
  logic [ADDR_WIDTH:0]     r_beat_cnt;
  logic [ADDR_WIDTH:0]     r_memz_addr;
  logic                    r_rd_pend;
  logic                    r_rd_last;
  logic                    r_busy;
  logic                    r_done;

  logic [ADDR_WIDTH:0]     w_len;
  logic [ADDR_WIDTH:0]     w_next_addr;
  logic                    w_start_acc;
  logic                    w_xfer;
  logic                    w_final;
  logic                    w_issue;
  logic [1:0]              w_fill;
  logic                    w_buf_valid;
  logic                    w_buf_last;
  logic [2*DATA_WIDTH-1:0] w_buf_data;
  logic [1:0]              w_buf_count;

  // N = sizeX+sizeY-1, widened by one bit so the sum cannot wrap.
  always_comb begin
    w_len = '0;
    if (sizeX != '0 && sizeY != '0)
      w_len = {1'b0, sizeX} + {1'b0, sizeY} - L_ONE;
  end

  assign w_start_acc = start && (r_state == IDLE);
  assign w_xfer      = w_buf_valid && bus.m_ready;
  assign w_final     = w_xfer && (r_beat_cnt == r_len - L_ONE);
  assign w_next_addr = r_issue_cnt + L_ONE;

  // Slots committed after this edge: buffered beats, minus the one leaving
  // now, plus the read whose data lands now. Counting the departing beat is
  // what lets a new read go out every cycle at full rate.
  assign w_fill  = w_buf_count + {1'b0, r_rd_pend} - {1'b0, w_xfer};
  assign w_issue = (r_state == STREAM) && (r_issue_cnt < r_len) && (w_fill < 2'd2);

  // memZ_addr always presents the next address to read, so the memory
  // samples it on the very edge the read is issued and the data is pushed
  // one edge later. It stops at N-1 rather than running past the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_memz_addr <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_rd_last <= w_issue && (r_issue_cnt == r_len - L_ONE);
      if (w_issue) begin
        r_issue_cnt <= w_next_addr;
        if (w_next_addr < r_len)
          r_memz_addr <= w_next_addr;
      end
      if (w_xfer)
        r_beat_cnt <= r_beat_cnt + L_ONE;

      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_start_acc) begin
            r_len       <= w_len;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_memz_addr <= '0;
            r_busy      <= 1'b1;
            if (w_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_final) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  conv_rd_skid_buf #(
    .W(2*DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (r_rd_pend),
    .i_push_last (r_rd_last),
    .i_push_data (bus.dataZ),
    .i_pop       (w_xfer),
    .o_valid     (w_buf_valid),
    .o_last      (w_buf_last),
    .o_data      (w_buf_data),
    .o_count     (w_buf_count)
  );

  assign bus.memZ_addr = r_memz_addr;
  assign bus.m_data    = w_buf_data;
  assign bus.m_valid   = w_buf_valid;
  assign bus.m_last    = w_buf_last;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

`ifdef CONV_RD_CHECKSUM_EN
  logic [2*DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_checksum <= '0;
    else if (w_start_acc)
      r_checksum <= '0;
    else if (w_xfer)
      r_checksum <= r_checksum + w_buf_data;
  end

  assign checksum_out = r_checksum;
`endif

endmodule
